// File: rtl/td4_clk_ctrl.sv
// td4_clk_ctrl: clock-enable sequencer for the TD4 core.
//
// Turns debounced switch levels and the CPU halt request into a single-cycle
// CPU clock enable. Modes are manual single-step, slow auto-run, fast auto-run
// and halted; this block is the only source of CPU advance.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST     in   synchronous reset, active-low
//   MODE_I  in   debounced mode switch level (1 = pressed)
//   STEP_I  in   debounced step button level (1 = pressed)
//   HALT_I  in   CPU halt request level
//   CE_O    out  CPU clock enable, one-cycle pulse per CPU step
//   MODE_O  out  current mode: 00 STEP, 01 SLOW, 10 FAST, 11 HALT
//   CLK_LED_O out (only with TD4_CLK_LED_EN) toggles on every CE pulse
//
// Optional feature macro: TD4_CLK_LED_EN adds the CLK_LED_O output.

module td4_clk_ctrl #(
    parameter int unsigned SLOW_DIV = 1000000,
    parameter int unsigned FAST_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MODE_I,
    input  logic       STEP_I,
    input  logic       HALT_I,
    output logic       CE_O,
`ifdef TD4_CLK_LED_EN
    output logic       CLK_LED_O,
`endif
    output logic [1:0] MODE_O
);

    localparam int unsigned CW = $clog2(SLOW_DIV);
    localparam logic [CW-1:0] SlowLast = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] FastLast = CW'(FAST_DIV - 1);

    // Encodings double as the MODE_O value.
    typedef enum logic [1:0] {
        StStep = 2'b00,
        StSlow = 2'b01,
        StFast = 2'b10,
        StHalt = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce_q, ce_d;
    logic          mode_prev_q, mode_prev_d;
    logic          step_prev_q, step_prev_d;
    logic          mode_press, step_press;
    logic [CW-1:0] cnt_last;

    assign mode_press = MODE_I & ~mode_prev_q;
    assign step_press = STEP_I & ~step_prev_q;
    assign cnt_last   = (state_q == StSlow) ? SlowLast : FastLast;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ce_d        = 1'b0;
        mode_prev_d = MODE_I;
        step_prev_d = STEP_I;

        if (HALT_I && state_q != StHalt) begin
            // Halt beats everything, including a trigger on this edge.
            state_d = StHalt;
            cnt_d   = '0;
        end else if (mode_press) begin
            // A mode change swallows any step press or terminal count.
            cnt_d = '0;
            unique case (state_q)
                StStep:  state_d = StSlow;
                StSlow:  state_d = StFast;
                StFast:  state_d = StStep;
                StHalt:  state_d = HALT_I ? StHalt : StStep;
                default: state_d = StStep;
            endcase
        end else begin
            unique case (state_q)
                StStep: begin
                    ce_d = step_press;
                end
                StSlow, StFast: begin
                    if (cnt_q == cnt_last) begin
                        cnt_d = '0;
                        ce_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StHalt: begin
                    cnt_d = '0;
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= StStep;
            cnt_q       <= '0;
            ce_q        <= 1'b0;
            // Loading 1 hides a switch held through reset until it is re-pressed.
            mode_prev_q <= 1'b1;
            step_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            mode_prev_q <= mode_prev_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign CE_O   = ce_q;
    assign MODE_O = state_q;

`ifdef TD4_CLK_LED_EN
    logic led_q, led_d;

    always_comb begin
        led_d = led_q ^ ce_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign CLK_LED_O = led_q;
`endif

endmodule

// File: tb/tb_td4_clk_ctrl.sv
// Directed bench for td4_clk_ctrl (SLOW_DIV=20, FAST_DIV=5).
// Expected CE edges are queued as stimulus is driven; a monitor compares
// CE_O (and CLK_LED_O when enabled) every cycle against the queue head.

module tb_td4_clk_ctrl;

    localparam int unsigned SDIV = 20;
    localparam int unsigned FDIV = 5;

    logic       CLK = 1'b0;
    logic       RST;
    logic       MODE_I;
    logic       STEP_I;
    logic       HALT_I;
    logic       CE_O;
    logic [1:0] MODE_O;
`ifdef TD4_CLK_LED_EN
    logic       CLK_LED_O;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ceq[$];
    logic rst_at_edge = 1'b0;
    logic led_exp     = 1'b0;

    td4_clk_ctrl #(
        .SLOW_DIV(SDIV),
        .FAST_DIV(FDIV)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .MODE_I   (MODE_I),
        .STEP_I   (STEP_I),
        .HALT_I   (HALT_I),
        .CE_O     (CE_O),
`ifdef TD4_CLK_LED_EN
        .CLK_LED_O(CLK_LED_O),
`endif
        .MODE_O   (MODE_O)
    );

    always #5 CLK = ~CLK;

    // cyc = index of the most recent rising edge.
    always @(posedge CLK) begin
        cyc         <= cyc + 1;
        rst_at_edge <= RST;
    end

    always @(negedge CLK) begin
        logic exp_ce;
        exp_ce = (ceq.size() > 0) && (ceq[0] == cyc);
        total++;
        assert (CE_O === exp_ce) else begin
            bad++;
            $error("FAIL ce edge=%0d observed=%b expected=%b", cyc, CE_O, exp_ce);
        end
        if (exp_ce) void'(ceq.pop_front());
`ifdef TD4_CLK_LED_EN
        if (!rst_at_edge) led_exp = 1'b0;
        else if (exp_ce) led_exp = ~led_exp;
        total++;
        assert (CLK_LED_O === led_exp) else begin
            bad++;
            $error("FAIL led edge=%0d observed=%b expected=%b", cyc, CLK_LED_O, led_exp);
        end
`endif
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_mode(input string tag, input logic [1:0] exp_m);
        total++;
        assert (MODE_O === exp_m) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, MODE_O, exp_m);
        end
    endtask

    task automatic press_step(input int hold);
        STEP_I = 1'b1;
        ceq.push_back(cyc + 1);
        repeat (hold) tick();
        STEP_I = 1'b0;
        tick();
        tick();
    endtask

    // Press MODE to enter mode exp_m at edge e; the next mode/halt event
    // lands on edge e+dwell. Auto-run pulses before that edge are queued.
    task automatic enter(input string tag, input logic [1:0] exp_m, input int div,
                         input int dwell);
        int e;
        e = cyc + 1;
        MODE_I = 1'b1;
        if (div > 0) begin
            for (int k = 1; k * div < dwell; k++) ceq.push_back(e + k * div);
        end
        tick();
        check_mode(tag, exp_m);
        tick();
        tick();
        MODE_I = 1'b0;
        while (cyc < e + dwell - 1) tick();
    endtask

    initial begin
        int e;
        RST    = 1'b0;
        MODE_I = 1'b1;
        STEP_I = 1'b1;
        HALT_I = 1'b0;

        // Reset with both switches held, then keep holding after release.
        repeat (3) tick();
        check_mode("reset", 2'b00);
        RST = 1'b1;
        repeat (5) begin
            tick();
            check_mode("held_through_reset", 2'b00);
        end
        MODE_I = 1'b0;
        STEP_I = 1'b0;
        tick();
        tick();

        // Manual stepping: long hold gives one pulse, second press one more.
        press_step(15);
        press_step(3);
        check_mode("step_mode", 2'b00);

        // Mode cycle with auto-run pulse timing.
        enter("to_slow", 2'b01, SDIV, 45);
        enter("to_fast", 2'b10, FDIV, 17);
        enter("to_step", 2'b00, 0, 6);

        // SLOW with mode press at prescaler=5, then FAST halted at terminal count.
        enter("to_slow2", 2'b01, SDIV, 6);
        enter("slow_to_fast", 2'b10, FDIV, 25);
        HALT_I = 1'b1;
        tick();
        check_mode("halt_at_tc", 2'b11);
        MODE_I = 1'b1;
        tick();
        check_mode("mode_while_halt", 2'b11);
        tick();
        MODE_I = 1'b0;
        STEP_I = 1'b1;
        tick();
        STEP_I = 1'b0;
        tick();
        check_mode("step_in_halt", 2'b11);
        HALT_I = 1'b0;
        tick();
        MODE_I = 1'b1;
        tick();
        check_mode("halt_release", 2'b00);
        tick();
        MODE_I = 1'b0;
        tick();
        tick();

        // MODE and STEP on the same edge: mode wins, step dropped.
        e = cyc + 1;
        MODE_I = 1'b1;
        STEP_I = 1'b1;
        ceq.push_back(e + SDIV);
        tick();
        check_mode("collision", 2'b01);
        tick();
        tick();
        MODE_I = 1'b0;
        STEP_I = 1'b0;
        while (cyc < e + SDIV) tick();

        // Reset while a CE pulse is high clears it.
        RST = 1'b0;
        tick();
        check_mode("mid_reset", 2'b00);
        RST = 1'b1;
        repeat (3) tick();
        check_mode("after_reset", 2'b00);

        total++;
        assert (ceq.size() == 0) else begin
            bad++;
            $error("FAIL ce_queue_empty observed=%0d expected=0", ceq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/td4_clk_ctrl.md
Name: td4_clk_ctrl

Overview:
- Clock-enable sequencer for the TD4 core. Consumes debounced switch levels from the chatter filters (mode switch, step button) and a halt request from the CPU. Produces a single-cycle CPU clock enable.
- Modes: manual single-step, slow auto-run, fast auto-run and halted. Sits between the chatter filters and the CPU register enables, and is the only source of CPU advance.

Parameters:
- SLOW_DIV, 1000000, CLK cycles per CE pulse in SLOW mode (1 Hz at 1 MHz CLK); must be >= 2.
- FAST_DIV, 100000, CLK cycles per CE pulse in FAST mode (10 Hz at 1 MHz CLK); must be >= 2 and <= SLOW_DIV.

Ports:
- CLK, input, 1, system clock; all logic on the rising edge.
- RST, input, 1, synchronous reset, active-low (0 = reset, sampled on the CLK rising edge).
- MODE_I, input, 1, debounced mode switch level; 1 = pressed.
- STEP_I, input, 1, debounced step button level; 1 = pressed.
- HALT_I, input, 1, CPU halt request level.
- CE_O, output, 1, CPU clock enable; one-CLK-cycle pulse per CPU step.
- MODE_O, output, 2, current mode: 00 STEP, 01 SLOW, 10 FAST, 11 HALT.

Behaviour:
- Reset (RST=0 at an edge):
  - state=STEP, MODE_O=00, CE_O=0, prescaler=0.
  - Edge-detect registers for MODE_I and STEP_I load 1. A switch held through reset therefore produces no event until it is released and pressed again.
- Edge detect: a press event occurs at edge k when the input is sampled 1 at k and was sampled 0 at k-1. The previous-sample registers update every non-reset cycle.
- State transitions, evaluated at each edge in priority order:
  1. HALT_I=1 in STEP, SLOW or FAST -> HALT. A CE trigger in the same cycle is dropped.
  2. MODE press: STEP->SLOW, SLOW->FAST, FAST->STEP, HALT->STEP. HALT->STEP happens only when HALT_I=0; if HALT_I=1 the state stays HALT.
  3. Otherwise hold.
- CE generation: CE_O is registered and is high for exactly the cycle after a trigger edge.
  - STEP: a STEP press at edge k with no MODE press and HALT_I=0 gives CE_O=1 after edge k and 0 after edge k+1. STEP presses in other modes are discarded.
  - SLOW/FAST:
    - The prescaler counts 0..DIV-1. At the edge where it equals DIV-1, it wraps to 0 and CE_O is set to 1.
    - Entry to SLOW or FAST at edge e clears the prescaler to 0. The first CE_O is high after edge e+DIV, then every DIV cycles exactly.
  - HALT: CE_O=0 and the prescaler is held at 0.
- Simultaneous events:
  - A MODE press and a STEP press at the same edge: the mode change wins and the step is discarded.
  - A MODE press at the prescaler terminal count: the mode change wins, no CE, and the prescaler clears.
- Any mode change clears the prescaler to 0.
- Prescaler width is $clog2(SLOW_DIV). FAST uses the same counter compared against FAST_DIV-1.
- Reset mid-operation overrides everything. A CE_O pulse in flight is cleared at the reset edge.
- MODE_O is registered and equals the state encoding; it updates on the same edge as the state.

Optional Feature:
- Macro TD4_CLK_LED_EN.
- Defined: adds output CLK_LED_O (1 bit, reset 0). It toggles on every edge where CE_O is set to 1, giving a visible 50%-duty CPU clock for the board LED.
- Undefined: the CLK_LED_O port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset: RST=0 for 3 cycles with MODE_I=1 and STEP_I=1, then RST=1 with both held for 5 cycles -> MODE_O=00, CE_O=0 throughout, no mode change.
- Step: SLOW_DIV=20, FAST_DIV=5. STEP_I 0->1 sampled at edge k, held 15 cycles -> CE_O=1 only in the cycle after k. A second press gives exactly one more pulse.
- Mode cycle: press MODE_I 3 times, each press 3 cycles separated by 3 low cycles -> MODE_O goes 00->01->10->00.
  - In SLOW, CE_O pulses exactly every 20 cycles, first pulse 20 cycles after entry.
  - In FAST, every 5 cycles.
- Halt: in FAST, raise HALT_I at the same edge as the prescaler terminal count -> MODE_O=11 and no CE_O pulse.
  - A MODE press while HALT_I=1 -> stays 11.
  - HALT_I=0 then a MODE press -> MODE_O=00.
- Collision: in STEP mode, MODE and STEP pressed on the same edge -> MODE_O=01, no CE_O pulse. In SLOW at prescaler=5, a MODE press -> FAST, first CE 5 cycles later.
- With TD4_CLK_LED_EN defined: 4 CE pulses in FAST -> CLK_LED_O sequence 1,0,1,0. Without the macro, the build has no CLK_LED_O port.
